// File: rtl/mmseq_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
package mmseq_pkg;

  localparam int WIDTH_W = 4;
  localparam int CNT_W   = 5;
  localparam logic [CNT_W-1:0] ZERO_WIDTH_N = 5'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A programmed width of 0 encodes the full 16-element row/column.
  function automatic logic [CNT_W-1:0] width_to_n(input logic [WIDTH_W-1:0] w);
    return (w == '0) ? ZERO_WIDTH_N : {1'b0, w};
  endfunction

endpackage

// File: rtl/mmseq_cnt.sv
// Loadable 5-bit down counter; zero_nxt flags the decrement that reaches zero.
// Latency: load/decrement visible the cycle after; no backpressure (en gates it).
module mmseq_cnt
  import mmseq_pkg::*;
(
  input  logic             clk,
  input  logic             resetl,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero_nxt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  assign zero_nxt = en & ~load & (cnt_q == 5'd1);

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mmseq.sv
// Matrix-multiply element sequencer; stall honoured only with MMSEQ_STALL_EN.
// Latency: RUN starts the cycle after go, N issue cycles, 2-cycle DRAIN ending in done.
// Backpressure: stall freezes RUN; address writes while busy are dropped and flag wr_err.
module mmseq
  import mmseq_pkg::*;
(
  input  logic               clk,
  input  logic               resetl,
  input  logic               mtxc_wr,
  input  logic               mtxa_wr,
  input  logic [4:0]         gpu_din,
  input  logic               mmult_go,
  input  logic               stall,
  output logic [WIDTH_W-1:0] mwidth,
  output logic               maddw,
  output logic               cntld,
  output logic               cnten,
  output logic               mac_en,
  output logic               mac_first,
  output logic               busy,
  output logic               done,
  output logic               wr_err
);

  state_t               state_q, state_d;
  logic                 dly_q, dly_d;
  logic                 first_q, first_d;
  logic [WIDTH_W-1:0]   mwidth_q, mwidth_d;
  logic                 maddw_q, maddw_d;
  logic                 wr_err_q, wr_err_d;
  logic                 adv;
  logic                 cnt_load;
  logic                 cnt_en;
  logic                 zero_nxt;

`ifdef MMSEQ_STALL_EN
  assign adv = ~stall;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign adv = 1'b1;
`endif

  assign cnt_load = (state_q == IDLE) & mmult_go;
  assign cnt_en   = (state_q == RUN) & adv;

  mmseq_cnt u_cnt (
    .clk      (clk),
    .resetl   (resetl),
    .load     (cnt_load),
    .load_val (width_to_n(mwidth_q)),
    .en       (cnt_en),
    .zero_nxt (zero_nxt)
  );

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q  <= IDLE;
      dly_q    <= 1'b0;
      first_q  <= 1'b0;
      mwidth_q <= '0;
      maddw_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      first_q  <= first_d;
      mwidth_q <= mwidth_d;
      maddw_q  <= maddw_d;
      wr_err_q <= wr_err_d;
    end
  end

  // DRAIN spans two cycles: one for the last RAM read to land, one for done.
  always_comb begin
    state_d  = state_q;
    dly_d    = 1'b0;
    first_d  = first_q;
    mwidth_d = mtxc_wr ? gpu_din[3:0] : mwidth_q;
    maddw_d  = mtxc_wr ? gpu_din[4]   : maddw_q;
    wr_err_d = wr_err_q | (mtxa_wr & (state_q != IDLE));
    if (cnt_load)    first_d = 1'b1;
    else if (cnt_en) first_d = 1'b0;
    case (state_q)
      IDLE:    if (mmult_go) state_d = RUN;
      RUN:     if (zero_nxt) state_d = DRAIN;
      DRAIN: begin
        if (dly_q) state_d = IDLE;
        else       dly_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    cnten     = cnt_en;
    mac_en    = cnt_en;
    mac_first = cnt_en & first_q;
    done      = (state_q == DRAIN) & dly_q;
    cntld     = mtxa_wr & ~busy & resetl;
    mwidth    = mwidth_q;
    maddw     = maddw_q;
    wr_err    = wr_err_q;
  end

endmodule

// File: tb/tb_mmseq.sv
// Directed bench for mmseq: per-scenario tasks with inline expected values.
module tb_mmseq;

  logic       clk = 1'b0;
  logic       resetl = 1'b0;
  logic       mtxc_wr = 1'b0;
  logic       mtxa_wr = 1'b0;
  logic [4:0] gpu_din = '0;
  logic       mmult_go = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] mwidth;
  logic       maddw, cntld, cnten, mac_en, mac_first, busy, done, wr_err;

  int checks = 0;
  int passes = 0;

  int n_cnten, n_first, n_busy, n_done, first_idx, last_idx, done_idx;
  int mac_bad, maddw_bad, overlap;

  mmseq dut (
    .clk(clk), .resetl(resetl), .mtxc_wr(mtxc_wr), .mtxa_wr(mtxa_wr),
    .gpu_din(gpu_din), .mmult_go(mmult_go), .stall(stall),
    .mwidth(mwidth), .maddw(maddw), .cntld(cntld), .cnten(cnten),
    .mac_en(mac_en), .mac_first(mac_first), .busy(busy), .done(done),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) $display("FAIL %s: got %0d expected %0d", name, got, want);
    else passes++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic setw(input logic [4:0] v);
    step(); mtxc_wr = 1'b1; gpu_din = v;
    step(); mtxc_wr = 1'b0;
  endtask

  task automatic start_op();
    step(); mmult_go = 1'b1;
    step(); mmult_go = 1'b0;
  endtask

  // Samples 40 cycles after go; optionally stalls or injects go+mtxc_wr mid-run.
  task automatic collect(input int stall_after, input int stall_len, input bit inject,
                         input logic exp_maddw);
    int  left = 0;
    bit  stalled = 0;
    n_cnten = 0; n_first = 0; n_busy = 0; n_done = 0;
    first_idx = -1; last_idx = -1; done_idx = -1;
    mac_bad = 0; maddw_bad = 0; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cnten) begin n_cnten++; last_idx = i; end
      if (mac_en !== cnten) mac_bad++;
      if (mac_first) begin n_first++; if (first_idx < 0) first_idx = i; end
      if (busy) begin n_busy++; if (maddw !== exp_maddw) maddw_bad++; end
      if (done) begin n_done++; if (done_idx < 0) done_idx = i; end
      if (cntld && cnten) overlap++;
      if (left > 0) begin left--; if (left == 0) stall = 1'b0; end
      if (stall_len > 0 && !stalled && n_cnten == stall_after) begin
        stall = 1'b1; left = stall_len; stalled = 1;
      end
      if (inject && i == 0) begin mmult_go = 1'b1; mtxc_wr = 1'b1; gpu_din = 5'h02; end
      if (inject && i == 1) begin mmult_go = 1'b0; mtxc_wr = 1'b0; end
    end
  endtask

  task automatic test_reset();
    resetl = 1'b0; mtxa_wr = 1'b1;
    #2;
    chk("rst_cntld", cntld, 0);
    chk("rst_outs", {cnten, mac_en, mac_first, busy, done}, 0);
    chk("rst_mwidth", mwidth, 0);
    chk("rst_maddw_wrerr", {maddw, wr_err}, 0);
    mtxa_wr = 1'b0;
    step(); step();
    resetl = 1'b1;
  endtask

  task automatic test_basic();
    setw(5'h03);
    chk("basic_mwidth", mwidth, 3);
    start_op();
    collect(0, 0, 0, 1'b0);
    chk("basic_cnten", n_cnten, 3);
    chk("basic_first_cnt", n_first, 1);
    chk("basic_first_idx", first_idx, 0);
    chk("basic_last_idx", last_idx, 2);
    chk("basic_done_idx", done_idx, 4);
    chk("basic_done_cnt", n_done, 1);
    chk("basic_busy", n_busy, 5);
    chk("basic_mac_en", mac_bad, 0);
    chk("basic_overlap", overlap, 0);
  endtask

  task automatic test_width16_col();
    setw(5'h10);
    chk("w16_mwidth", mwidth, 0);
    chk("w16_maddw_reg", maddw, 1);
    start_op();
    collect(0, 0, 0, 1'b1);
    chk("w16_cnten", n_cnten, 16);
    chk("w16_maddw", maddw_bad, 0);
    chk("w16_done_idx", done_idx, 17);
    chk("w16_busy", n_busy, 18);
    chk("w16_first", n_first, 1);
  endtask

  task automatic test_stall();
    setw(5'h04);
    start_op();
    collect(2, 2, 0, 1'b0);
    chk("stall_cnten", n_cnten, 4);
    chk("stall_first", n_first, 1);
    chk("stall_mac_en", mac_bad, 0);
    chk("stall_done_cnt", n_done, 1);
`ifdef MMSEQ_STALL_EN
    chk("stall_last_idx", last_idx, 5);
    chk("stall_done_idx", done_idx, 7);
`else
    chk("stall_last_idx", last_idx, 3);
    chk("stall_done_idx", done_idx, 5);
`endif
  endtask

  task automatic test_addr_wr();
    int waited = 0;
    setw(5'h04);
    step(); mtxa_wr = 1'b1;
    @(negedge clk);
    chk("addr_idle_cntld", cntld, 1);
    step(); mtxa_wr = 1'b0;
    @(negedge clk);
    chk("addr_idle_wrerr", wr_err, 0);
    start_op();
    mtxa_wr = 1'b1;
    @(negedge clk);
    chk("addr_run_busy", busy, 1);
    chk("addr_run_cntld", cntld, 0);
    step(); mtxa_wr = 1'b0;
    @(negedge clk);
    chk("addr_run_wrerr", wr_err, 1);
    while (busy && waited < 40) begin @(negedge clk); waited++; end
    chk("addr_finish_timeout", (waited < 40) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    chk("addr_wrerr_sticky", wr_err, 1);
  endtask

  task automatic test_back_to_back();
    setw(5'h05);
    start_op();
    collect(0, 0, 1, 1'b0);
    chk("b2b_cnten", n_cnten, 5);
    chk("b2b_done_cnt", n_done, 1);
    chk("b2b_mwidth", mwidth, 2);
    start_op();
    collect(0, 0, 0, 1'b0);
    chk("b2b_next_cnten", n_cnten, 2);
    chk("b2b_next_done_idx", done_idx, 3);
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    int bz = 0;
    setw(5'h06);
    start_op();
    step();
    mtxa_wr = 1'b1;
    resetl = 1'b0;
    #1;
    chk("midrst_outs", {cntld, cnten, mac_en, mac_first, busy, done}, 0);
    chk("midrst_mwidth", mwidth, 0);
    mtxa_wr = 1'b0;
    step();
    resetl = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
    chk("midrst_no_done", dn, 0);
    chk("midrst_idle", bz, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width16_col();
    test_stall();
    test_addr_wr();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
